// File: rtl/smi_frame_pkg.sv
// SMI frame constants and header packing shared by the read (and future write) splitters.
// Header fields are little-endian byte lanes within the first flit.
package smi_frame_pkg;

    localparam logic [7:0] READ_REQ_ID  = 8'h02;
    localparam logic [7:0] WRITE_REQ_ID = 8'h01;
    localparam logic [7:0] ID_BYTE_MASK = 8'hFF;

    localparam int unsigned HDR_TAG_OFS        = 1;
    localparam int unsigned HDR_ADDR_OFS       = 4;
    localparam int unsigned HDR_LEN_OFS        = 12;
    localparam int unsigned READ_REQ_HDR_BYTES = 14;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } split_state_e;

    // Builds the 16-byte read-request header; bytes 2-3 and 14-15 stay zero.
    function automatic logic [127:0] pack_read_req(input logic [7:0]  tag,
                                                   input logic [63:0] addr,
                                                   input logic [12:0] len);
        logic [127:0] hdr;
        hdr                         = '0;
        hdr[7:0]                    = READ_REQ_ID & ID_BYTE_MASK;
        hdr[HDR_TAG_OFS*8 +: 8]     = tag;
        hdr[HDR_ADDR_OFS*8 +: 64]   = addr;
        hdr[HDR_LEN_OFS*8 +: 16]    = 16'(len);
        return hdr;
    endfunction

endpackage

// File: rtl/smi_read_burst_splitter_if.sv
// Command and SMI request-port bundle of the read burst splitter.
// master = command issuer / frame consumer, slave = splitter.
interface smi_read_burst_splitter_if #(
    parameter int unsigned DataIndexSize = 4
);
    localparam int unsigned FlitWidth = 1 << DataIndexSize;

    logic                   cmdValid;
    logic                   cmdReady;
    logic [63:0]            cmdAddr;
    logic [31:0]            cmdLength;
    logic                   cmdDone;
    logic                   smiReqReady;
    logic [7:0]             smiReqEofc;
    logic [FlitWidth*8-1:0] smiReqData;
    logic                   smiReqStop;

    modport master (
        output cmdValid, cmdAddr, cmdLength, smiReqStop,
        input  cmdReady, cmdDone, smiReqReady, smiReqEofc, smiReqData
    );

    modport slave (
        input  cmdValid, cmdAddr, cmdLength, smiReqStop,
        output cmdReady, cmdDone, smiReqReady, smiReqEofc, smiReqData
    );

endinterface

// File: rtl/smi_read_chunk_calc.sv
// Chunk length = min(remaining, MaxBurstBytes, bytes left in the current 4 KiB page).
// Only the page offset of the address matters, so only addr[11:0] is taken.
module smi_read_chunk_calc #(
    parameter int unsigned MaxBurstBytes = 256
) (
    input  logic [11:0] addr_lo_i,
    input  logic [31:0] remaining_i,
    output logic [12:0] len_o
);

    logic [12:0] page_room;
    logic [12:0] rem_cap;

    always_comb begin
        page_room = 13'h1000 - {1'b0, addr_lo_i};
        rem_cap   = (remaining_i > 32'h1000) ? 13'h1000 : remaining_i[12:0];
        len_o     = 13'(MaxBurstBytes);
        if (page_room < len_o) len_o = page_room;
        if (rem_cap < len_o)   len_o = rem_cap;
    end

endmodule

// File: rtl/smi_read_burst_splitter.sv
// Splits one linear read command into single-flit SMI read-request frames,
// bounded by MaxBurstBytes and 4 KiB pages, tagging each frame.
module smi_read_burst_splitter
    import smi_frame_pkg::*;
#(
    parameter int unsigned DataIndexSize = 4,
    parameter int unsigned MaxBurstBytes = 256,
    parameter int unsigned TagWidth      = 4
) (
    input  logic                      clk,
    input  logic                      srst,
    smi_read_burst_splitter_if.slave  bus
);

    localparam int unsigned DataW = (1 << DataIndexSize) * 8;

    split_state_e        state_q, state_d;
    logic [63:0]         addr_q, addr_d;
    logic [31:0]         rem_q, rem_d;
    logic [TagWidth-1:0] tag_q, tag_d;
    logic                done_q, done_d;
    logic [12:0]         chunk_len;

    smi_read_chunk_calc #(
        .MaxBurstBytes (MaxBurstBytes)
    ) u_chunk_calc (
        .addr_lo_i   (addr_q[11:0]),
        .remaining_i (rem_q),
        .len_o       (chunk_len)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        tag_d   = tag_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.cmdValid) begin
                    if (bus.cmdLength == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = bus.cmdAddr;
                        rem_d   = bus.cmdLength;
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                // Advancing addr/rem on transfer makes the next frame visible the next cycle.
                if (!bus.smiReqStop) begin
                    addr_d = addr_q + 64'(chunk_len);
                    rem_d  = rem_q - 32'(chunk_len);
                    tag_d  = tag_q + TagWidth'(1);
                    if (rem_q == 32'(chunk_len)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Frame fields derive only from flops, so they hold while stalled.
    always_comb begin
        bus.cmdReady    = (state_q == StIdle);
        bus.cmdDone     = done_q;
        bus.smiReqReady = (state_q == StSend);
        bus.smiReqEofc  = '0;
        bus.smiReqData  = '0;
        if (state_q == StSend) begin
            bus.smiReqEofc = 8'(READ_REQ_HDR_BYTES);
            bus.smiReqData = DataW'(pack_read_req(8'(tag_q), addr_q, chunk_len));
        end
    end

endmodule

// File: doc/smi_read_burst_splitter.md
Name: smi_read_burst_splitter

Overview:
- Upstream neighbour of the SMI-to-AXI bus adaptor.
- Accepts one arbitrary-length linear read command (64-bit byte address, 32-bit byte count).
- Splits it into SMI read-request frames, each no longer than MaxBurstBytes and never crossing a 4 KiB boundary.
- Drives the frames onto the adaptor's SMI request port, tags each frame and pulses done after the last frame transfers.

Parameters:
- DataIndexSize, 4: log2 of flit bytes; FlitWidth = 1<<DataIndexSize, minimum 16.
- MaxBurstBytes, 256: maximum bytes per request frame; power of two, FlitWidth..4096.
- TagWidth, 4: width of the tag counter; 1..8.

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous active-high reset.
- cmdValid  in  1  command offered.
- cmdReady  out  1  high when IDLE; transfer on cmdValid&cmdReady.
- cmdAddr  in  64  start byte address.
- cmdLength  in  32  byte count; 0 allowed.
- cmdDone  out  1  one-cycle pulse at command completion.
- smiReqReady  out  1  frame flit valid.
- smiReqEofc  out  8  end-of-frame count.
- smiReqData  out  FlitWidth*8  frame flit.
- smiReqStop  in  1  backpressure; a flit transfers on smiReqReady & !smiReqStop.

Behaviour:
- Clocking and reset: one clock, clk; reset srst is synchronous, active-high.
- Reset values: cmdReady=1, cmdDone=0, smiReqReady=0, smiReqEofc=0, smiReqData=0, tag counter=0, state=IDLE.
- Frame format: single flit, smiReqEofc=14 (14 valid bytes). Little-endian fields:
  - byte0 = 0x02 (read request).
  - byte1 = tag, zero-extended.
  - bytes2-3 = 0.
  - bytes4-11 = chunk address.
  - bytes12-13 = chunk byte count (1..MaxBurstBytes; 4096 encodes as 0x1000).
  - bytes 14 and up = 0.
- Chunk rule: len = min(remaining, MaxBurstBytes, 4096 - addr[11:0]). Computed combinationally from the registered addr/remaining.
- After each chunk: addr += len (modulo 2^64, wrap permitted); remaining -= len.
- States:
  - IDLE: cmdReady=1. On accept with cmdLength=0: stay IDLE, cmdDone=1 next cycle, no frame. On accept with cmdLength>0: latch the command and go to SEND. The first frame is presented with smiReqReady=1 on the cycle after acceptance.
  - SEND: cmdReady=0. Frame outputs are registered and held stable while smiReqStop=1. On transfer with remaining-len>0: load the next chunk in the same cycle, giving back-to-back frames at 1 per clk when unstalled. On transfer of the final chunk: smiReqReady=0, cmdDone=1 and state=IDLE, all on the next cycle. cmdReady returns 1 in that same cycle, so the next command can be accepted there (no bubble beyond one cycle).
- Tag: increments modulo 2^TagWidth after each transferred frame. It is not reset between commands, only by srst.
- smiReqStop while smiReqReady=0: ignored.
- cmdValid while cmdReady=0: ignored; the command input is not latched.
- srst mid-operation: abandons the current command immediately. Outputs take reset values on the following cycle, even if a frame was stalled. No cmdDone.
- Arithmetic widths: remaining is 32 bits; chunk length is 13 bits internally.

Decomposition:
- Shared package smi_frame_pkg holds:
  - Frame-type constants READ_REQ_ID=0x02 and WRITE_REQ_ID=0x01, plus ID_BYTE_MASK.
  - Header byte offsets (TAG=1, ADDR=4, LEN=12).
  - READ_REQ_HDR_BYTES=14.
- One combinational sub-module, smi_read_chunk_calc (addr, remaining -> len), is reusable by a future write splitter.
- Header packing and the state machine stay in the top.

Test Plan:
- Split across bursts: addr=0x100, len=600, no stop -> 3 consecutive-cycle frames.
  - Addr/len: 0x100/256, 0x200/256, 0x300/88.
  - Tags 0, 1, 2.
  - cmdDone one cycle after the 3rd transfer.
- 4 KiB crossing: addr=0x0FF0, len=0x30 -> frames 0x0FF0/16 and 0x1000/32. No frame crosses 0x1000.
- Stall: smiReqStop=1 for 3 cycles on frame 2 of the first case -> smiReqData/smiReqEofc bit-stable throughout. Frame 2 transfers once, with no duplicate or skip.
- Zero-length and back-to-back: cmdLength=0 -> no smiReqReady, cmdDone pulse the cycle after accept. A second command (0x0, 16) is then accepted and yields a single frame with len=16.
- Tag wrap: addr=0, len=17*256, TagWidth=4 -> 17 frames with tags 0..15, 0.
- Reset mid-operation: srst asserted during frame 2 of a 3-frame command -> next cycle smiReqReady=0, cmdReady=1, no cmdDone. The next command's first tag is 0.
